alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single X-stage ALU between the CPU pipeline (ID/EX issue) and the crypto coprocessor.
//  - Arbitrates one op per cycle and drives the ALU operand/opcode inputs combinationally.
//  - Captures alu_out and returns it to the winning requester one cycle later.
//  - CPU has priority. A starvation counter and a burst lock guarantee crypto forward progress.
// PARAMETERS
//  MAX_WAIT   4  cycles crypto may be refused while valid before it is force-granted (1..15)
//  BURST_LEN  8  max consecutive crypto grants while cry_lock held (1..15)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  cpu_req_valid  in   1   CPU op present
//  cpu_req_ready  out  1   CPU op accepted this cycle
//  cpu_opcode     in   5   CPU opcode
//  cpu_aluop      in   2   CPU R-format function
//  cpu_op_a       in   16  CPU operand 1
//  cpu_op_b       in   16  CPU operand 2 (reg or imm, already selected)
//  cry_req_valid  in   1   crypto op present
//  cry_req_ready  out  1   crypto op accepted this cycle
//  cry_lock       in   1   crypto requests a back-to-back burst
//  cry_opcode     in   5   crypto opcode
//  cry_aluop      in   2   crypto function
//  cry_op_a       in   16  crypto operand 1
//  cry_op_b       in   16  crypto operand 2
//  alu_opcode     out  5   to shared ALU
//  alu_aluop      out  2   to shared ALU
//  alu_in_1       out  16  to shared ALU
//  alu_in_2       out  16  to shared ALU
//  alu_flag_we    out  1   ALU may update Z/V/N; 1 only for a granted CPU op
//  alu_out        in   16  ALU result, combinational from alu_in_*
//  cpu_rsp_valid  out  1   CPU result valid
//  cpu_rsp_data   out  16  CPU result
//  cry_rsp_valid  out  1   crypto result valid
//  cry_rsp_data   out  16  crypto result
// BEHAVIOUR
//  - Handshake: a request is accepted when valid && ready. At most one ready is high per cycle.
//    ready depends on both valids and the state, never on alu_out.
//  - Idle slot (no grant): alu_opcode = 5'b11111, alu_aluop = 0, alu_in_* = 0, alu_flag_we = 0.
//  - Latency: an op accepted in cycle N gets rsp_valid = 1 in cycle N+1. rsp_data is alu_out
//    registered at N. There is no response backpressure. rsp_valid is a single-cycle pulse per op.
//  - States: PRI (CPU priority), FORCE (one forced crypto grant), BURST (crypto lock).
//  - PRI:
//    - cpu_valid -> grant CPU.
//    - Else cry_valid -> grant crypto.
//    - If cry_valid && cry_lock at a crypto grant -> BURST, burst_cnt = 1.
//    - wait_cnt: increments while cry_valid && CPU granted; clears on any crypto grant or !cry_valid.
//    - wait_cnt == MAX_WAIT -> FORCE next cycle.
//  - FORCE: grant crypto if cry_valid, CPU refused. Clear wait_cnt.
//    - Next state is BURST if cry_lock, else PRI.
//    - If cry_valid dropped: no grant, CPU may go, return to PRI.
//  - BURST: crypto granted every cycle while cry_valid && cry_lock; CPU refused.
//    - burst_cnt++ per grant.
//    - Exit to PRI when burst_cnt == BURST_LEN after a grant, or when cry_lock == 0, or when cry_valid == 0.
//    - Exit is on the same-cycle decision, with no grant in the exit cycle if the lock or valid dropped.
//  - Counters saturate and never wrap. wait_cnt and burst_cnt are 4 bits.
//  - Simultaneous valids in PRI when wait_cnt < MAX_WAIT: CPU wins.
//  - Reset (at any time, including mid-burst):
//    - State PRI, counters 0, both rsp_valid 0, rsp_data 16'h0000.
//    - A granted op from the reset cycle produces no response.
//  - Reset values: all outputs 0, except alu_opcode = 5'b11111.
// CONFIGURATION
//  ARB_STATS_EN defined:
//  - Adds outputs cpu_grant_cnt[15:0], cry_grant_cnt[15:0] and force_cnt[7:0].
//  - Each increments on its event and saturates at all-ones. Reset to 0.
//  ARB_STATS_EN undefined:
//  - These ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//  1. CPU only, ADD a=3, b=4 at cycle 5.
//     -> cpu_req_ready = 1 at 5; cpu_rsp_valid = 1, data = 7 at 6; alu_flag_we = 1 at 5.
//  2. Crypto only, XOR a=16'hF0F0, b=16'h0FF0.
//     -> cry_rsp_data = 16'hFF00 one cycle later; alu_flag_we = 0.
//  3. Both valid continuously, MAX_WAIT = 4.
//     -> CPU granted 4 cycles, crypto granted cycle 5, CPU again cycle 6; pattern repeats.
//  4. cry_lock held, BURST_LEN = 8, CPU valid throughout.
//     -> exactly 8 consecutive crypto grants, then CPU granted.
//     -> Drop cry_lock after 3 grants -> CPU granted the next cycle.
//  5. rst asserted during BURST, on the cycle after a crypto grant.
//     -> no cry_rsp_valid; state PRI and CPU granted the first cycle after rst falls.
//  6. ARB_STATS_EN build of scenario 3 over 20 cycles.
//     -> cpu_grant_cnt = 16, cry_grant_cnt = 4, force_cnt = 4.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares the single X-stage ALU between the CPU pipeline and the crypto
//   coprocessor. One op is granted per cycle, and that op drives the ALU
//   inputs combinationally. The ALU result is registered and returned to the
//   winner one cycle later. The CPU has priority. Crypto forward progress is
//   guaranteed in two ways: a starvation counter forces a crypto grant, and a
//   burst lock gives crypto back-to-back grants.
//
// Parameters
//   MAX_WAIT   cycles crypto may be refused while valid before a forced grant (1..15)
//   BURST_LEN  max consecutive crypto grants while cry_lock is held (1..15)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req_*  / cry_req_*      requester handshakes and op fields (cry_lock = burst request)
//   alu_opcode/aluop/in_1/in_2  combinational drive of the shared ALU
//   alu_flag_we                 ALU may update Z/V/N (granted CPU op only)
//   alu_out                     ALU result, combinational from alu_in_*
//   cpu_rsp_* / cry_rsp_*       one-cycle response pulse with registered result
//
// Configuration
//   ARB_STATS_EN  adds saturating counters cpu_grant_cnt, cry_grant_cnt and force_cnt
module alu_share_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [4:0]  cpu_opcode,
  input  logic [1:0]  cpu_aluop,
  input  logic [15:0] cpu_op_a,
  input  logic [15:0] cpu_op_b,
  input  logic        cry_req_valid,
  output logic        cry_req_ready,
  input  logic        cry_lock,
  input  logic [4:0]  cry_opcode,
  input  logic [1:0]  cry_aluop,
  input  logic [15:0] cry_op_a,
  input  logic [15:0] cry_op_b,
  output logic [4:0]  alu_opcode,
  output logic [1:0]  alu_aluop,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic        alu_flag_we,
  input  logic [15:0] alu_out,
  output logic        cpu_rsp_valid,
  output logic [15:0] cpu_rsp_data,
  output logic        cry_rsp_valid,
  output logic [15:0] cry_rsp_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] cpu_grant_cnt,
  output logic [15:0] cry_grant_cnt,
  output logic [7:0]  force_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam logic [CNT_W-1:0] MAX_WAIT_C  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [4:0]       IDLE_OPC    = 5'b11111;

  typedef enum logic [1:0] {ST_PRI, ST_FORCE, ST_BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_burst_nxt;
  logic               w_cpu_gnt, w_cry_gnt, w_force_gnt;
  logic               w_cpu_acc, w_cry_acc;
  logic               r_cpu_rsp_valid, r_cry_rsp_valid;
  logic [DATA_W-1:0]  r_cpu_rsp_data, r_cry_rsp_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // State register and arbitration counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PRI;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Grant decision and next state
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_burst_nxt = r_burst_cnt;
    w_cpu_gnt   = 1'b0;
    w_cry_gnt   = 1'b0;
    w_force_gnt = 1'b0;
    case (r_state)
      ST_PRI: begin
        if (cpu_req_valid) begin
          w_cpu_gnt = 1'b1;
          if (cry_req_valid) begin
            w_wait_nxt = sat_inc(r_wait_cnt);
            // Crypto has now been refused MAX_WAIT times: force it next cycle
            if (w_wait_nxt == MAX_WAIT_C) w_state_nxt = ST_FORCE;
          end else begin
            w_wait_nxt = '0;
          end
        end else if (cry_req_valid) begin
          w_cry_gnt  = 1'b1;
          w_wait_nxt = '0;
          if (cry_lock) begin
            w_burst_nxt = CNT_W'(1);
            // A one-grant burst is already complete
            w_state_nxt = (BURST_LEN <= 1) ? ST_PRI : ST_BURST;
          end
        end else begin
          w_wait_nxt = '0;
        end
      end
      ST_FORCE: begin
        w_wait_nxt  = '0;
        w_state_nxt = ST_PRI;
        if (cry_req_valid) begin
          w_cry_gnt   = 1'b1;
          w_force_gnt = 1'b1;
          if (cry_lock && (BURST_LEN > 1)) begin
            w_burst_nxt = CNT_W'(1);
            w_state_nxt = ST_BURST;
          end
        end else begin
          // Crypto withdrew, so the slot goes back to the CPU
          w_cpu_gnt = cpu_req_valid;
        end
      end
      ST_BURST: begin
        w_wait_nxt = '0;
        if (cry_req_valid && cry_lock) begin
          w_cry_gnt = 1'b1;
          if (sat_inc(r_burst_cnt) == BURST_LEN_C) begin
            w_burst_nxt = '0;
            w_state_nxt = ST_PRI;
          end else begin
            w_burst_nxt = sat_inc(r_burst_cnt);
          end
        end else begin
          // Lock or valid dropped: idle slot, return to CPU priority
          w_burst_nxt = '0;
          w_state_nxt = ST_PRI;
        end
      end
      default: begin
        w_state_nxt = ST_PRI;
        w_wait_nxt  = '0;
        w_burst_nxt = '0;
      end
    endcase
  end

  // No handshake completes while reset is asserted
  assign w_cpu_acc     = w_cpu_gnt & ~rst;
  assign w_cry_acc     = w_cry_gnt & ~rst;
  assign cpu_req_ready = w_cpu_acc;
  assign cry_req_ready = w_cry_acc;
  assign alu_flag_we   = w_cpu_acc;

  // Shared ALU operand mux; idle slot drives the NOP opcode
  always_comb begin
    alu_opcode = IDLE_OPC;
    alu_aluop  = '0;
    alu_in_1   = '0;
    alu_in_2   = '0;
    if (w_cpu_acc) begin
      alu_opcode = cpu_opcode;
      alu_aluop  = cpu_aluop;
      alu_in_1   = cpu_op_a;
      alu_in_2   = cpu_op_b;
    end else if (w_cry_acc) begin
      alu_opcode = cry_opcode;
      alu_aluop  = cry_aluop;
      alu_in_1   = cry_op_a;
      alu_in_2   = cry_op_b;
    end
  end

  // Result capture, returned to the winner one cycle after the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rsp_valid <= 1'b0;
      r_cry_rsp_valid <= 1'b0;
      r_cpu_rsp_data  <= '0;
      r_cry_rsp_data  <= '0;
    end else begin
      r_cpu_rsp_valid <= w_cpu_acc;
      r_cry_rsp_valid <= w_cry_acc;
      if (w_cpu_acc) r_cpu_rsp_data <= alu_out;
      if (w_cry_acc) r_cry_rsp_data <= alu_out;
    end
  end

  // Responses read as zero during reset so a pulse pending at reset is dropped
  assign cpu_rsp_valid = r_cpu_rsp_valid & ~rst;
  assign cry_rsp_valid = r_cry_rsp_valid & ~rst;
  assign cpu_rsp_data  = rst ? '0 : r_cpu_rsp_data;
  assign cry_rsp_data  = rst ? '0 : r_cry_rsp_data;

`ifdef ARB_STATS_EN
  logic [15:0] r_cpu_grant_cnt, r_cry_grant_cnt;
  logic [7:0]  r_force_cnt;

  // Saturating grant statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_grant_cnt <= '0;
      r_cry_grant_cnt <= '0;
      r_force_cnt     <= '0;
    end else begin
      if (w_cpu_acc && (r_cpu_grant_cnt != '1)) r_cpu_grant_cnt <= r_cpu_grant_cnt + 16'd1;
      if (w_cry_acc && (r_cry_grant_cnt != '1)) r_cry_grant_cnt <= r_cry_grant_cnt + 16'd1;
      if (w_force_gnt && (r_force_cnt != '1))   r_force_cnt     <= r_force_cnt + 8'd1;
    end
  end

  assign cpu_grant_cnt = r_cpu_grant_cnt;
  assign cry_grant_cnt = r_cry_grant_cnt;
  assign force_cnt     = r_force_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed scenarios followed by randomized traffic for alu_share_arbiter.
//   Every cycle is checked against a behavioural arbitration model. The bench
//   also provides a small stand-in ALU that drives alu_out.
module tb_alu_share_arbiter;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned BURST_LEN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready;
  logic [4:0]  cpu_opcode;
  logic [1:0]  cpu_aluop;
  logic [15:0] cpu_op_a, cpu_op_b;
  logic        cry_req_valid, cry_req_ready, cry_lock;
  logic [4:0]  cry_opcode;
  logic [1:0]  cry_aluop;
  logic [15:0] cry_op_a, cry_op_b;
  logic [4:0]  alu_opcode;
  logic [1:0]  alu_aluop;
  logic [15:0] alu_in_1, alu_in_2, alu_out;
  logic        alu_flag_we;
  logic        cpu_rsp_valid, cry_rsp_valid;
  logic [15:0] cpu_rsp_data, cry_rsp_data;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_grant_cnt, cry_grant_cnt;
  logic [7:0]  force_cnt;
`endif

  alu_share_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_opcode(cpu_opcode), .cpu_aluop(cpu_aluop), .cpu_op_a(cpu_op_a), .cpu_op_b(cpu_op_b),
    .cry_req_valid(cry_req_valid), .cry_req_ready(cry_req_ready), .cry_lock(cry_lock),
    .cry_opcode(cry_opcode), .cry_aluop(cry_aluop), .cry_op_a(cry_op_a), .cry_op_b(cry_op_b),
    .alu_opcode(alu_opcode), .alu_aluop(alu_aluop), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_flag_we(alu_flag_we), .alu_out(alu_out),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .cry_rsp_valid(cry_rsp_valid), .cry_rsp_data(cry_rsp_data)
`ifdef ARB_STATS_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .cry_grant_cnt(cry_grant_cnt), .force_cnt(force_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ALU: aluop 0 add, 1 sub, 2 and, 3 xor; idle opcode yields zero
  function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [1:0] fn,
                                        input logic [15:0] a, input logic [15:0] b);
    if (op == 5'b11111) return 16'h0000;
    case (fn)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_opcode, alu_aluop, alu_in_1, alu_in_2);

  int tests = 0;
  int fails = 0;

  // Reference model state: crypto refusals, pending forced slot, burst grants left
  int refused = 0;
  int burst_left = 0;
  bit force_pend = 1'b0;
  int m_cpu = 0, m_cry = 0, m_force = 0;
  bit exp_cpu_v = 1'b0, exp_cry_v = 1'b0;
  logic [15:0] exp_cpu_d = '0, exp_cry_d = '0;

  // Values sampled in the most recent step
  logic s_cpu_rdy, s_cry_rdy, s_flag, s_cpu_rsp_v, s_cry_rsp_v;
  logic [15:0] s_cpu_rsp_d, s_cry_rsp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic [4:0] op, input logic [1:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
    cpu_opcode = op; cpu_aluop = fn; cpu_op_a = a; cpu_op_b = b;
  endtask

  task automatic set_cry(input logic [4:0] op, input logic [1:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
    cry_opcode = op; cry_aluop = fn; cry_op_a = a; cry_op_b = b;
  endtask

  task automatic rand_fields();
    set_cpu(5'($urandom_range(0, 30)), 2'($urandom), 16'($urandom), 16'($urandom));
    set_cry(5'($urandom_range(0, 30)), 2'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // One clock cycle: drive, predict, check at negedge, advance the model
  task automatic step(input bit cv, input bit yv, input bit lk, input bit rs);
    bit e_cpu, e_cry, ev_cpu, ev_cry;
    logic [4:0] e_op;
    logic [1:0] e_fn;
    logic [15:0] e_a, e_b;
    cpu_req_valid = cv; cry_req_valid = yv; cry_lock = lk; rst = rs;
    e_cpu = 1'b0; e_cry = 1'b0;
    if (!rs) begin
      if (burst_left > 0) begin
        if (yv && lk) begin e_cry = 1'b1; burst_left--; end
        else burst_left = 0;
      end else if (force_pend) begin
        force_pend = 1'b0;
        if (yv) begin
          e_cry = 1'b1; m_force++;
          if (lk) burst_left = int'(BURST_LEN) - 1;
        end else begin
          e_cpu = cv;
        end
      end else if (cv) begin
        e_cpu = 1'b1;
        if (yv) begin
          refused++;
          if (refused == int'(MAX_WAIT)) begin force_pend = 1'b1; refused = 0; end
        end else begin
          refused = 0;
        end
      end else if (yv) begin
        e_cry = 1'b1; refused = 0;
        if (lk) burst_left = int'(BURST_LEN) - 1;
      end else begin
        refused = 0;
      end
    end
    e_op = 5'b11111; e_fn = 2'd0; e_a = 16'h0; e_b = 16'h0;
    if (e_cpu) begin e_op = cpu_opcode; e_fn = cpu_aluop; e_a = cpu_op_a; e_b = cpu_op_b; end
    else if (e_cry) begin e_op = cry_opcode; e_fn = cry_aluop; e_a = cry_op_a; e_b = cry_op_b; end
    ev_cpu = exp_cpu_v && !rs;
    ev_cry = exp_cry_v && !rs;

    @(negedge clk);
    s_cpu_rdy = cpu_req_ready; s_cry_rdy = cry_req_ready; s_flag = alu_flag_we;
    s_cpu_rsp_v = cpu_rsp_valid; s_cry_rsp_v = cry_rsp_valid;
    s_cpu_rsp_d = cpu_rsp_data; s_cry_rsp_d = cry_rsp_data;
    chk("cpu_ready", 32'(cpu_req_ready), 32'(e_cpu));
    chk("cry_ready", 32'(cry_req_ready), 32'(e_cry));
    chk("flag_we", 32'(alu_flag_we), 32'(e_cpu));
    chk("alu_op", 32'({alu_aluop, alu_opcode}), 32'({e_fn, e_op}));
    chk("alu_in", {alu_in_1, alu_in_2}, {e_a, e_b});
    chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(ev_cpu));
    chk("cry_rsp_valid", 32'(cry_rsp_valid), 32'(ev_cry));
    if (ev_cpu || rs) chk("cpu_rsp_data", 32'(cpu_rsp_data), rs ? 32'd0 : 32'(exp_cpu_d));
    if (ev_cry || rs) chk("cry_rsp_data", 32'(cry_rsp_data), rs ? 32'd0 : 32'(exp_cry_d));

    if (rs) begin
      refused = 0; burst_left = 0; force_pend = 1'b0;
      m_cpu = 0; m_cry = 0; m_force = 0;
      exp_cpu_v = 1'b0; exp_cry_v = 1'b0;
    end else begin
      exp_cpu_v = e_cpu; exp_cry_v = e_cry;
      if (e_cpu) begin exp_cpu_d = alu_f(cpu_opcode, cpu_aluop, cpu_op_a, cpu_op_b); m_cpu++; end
      if (e_cry) begin exp_cry_d = alu_f(cry_opcode, cry_aluop, cry_op_a, cry_op_b); m_cry++; end
    end
    @(posedge clk); #1;
  endtask

  task automatic grant_is(input string tag, input bit c, input bit y);
    chk(tag, 32'({s_cpu_rdy, s_cry_rdy}), 32'({c, y}));
  endtask

  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cry_req_valid = 1'b0; cry_lock = 1'b0;
    set_cpu('0, '0, '0, '0); set_cry('0, '0, '0, '0);
    @(posedge clk); #1;
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    grant_is("reset_grant", 1'b0, 1'b0);

    // CPU ADD 3+4
    set_cpu(5'd0, 2'd0, 16'd3, 16'd4);
    step(1, 0, 0, 0);
    grant_is("t1_grant", 1'b1, 1'b0);
    chk("t1_flag", 32'(s_flag), 32'd1);
    step(0, 0, 0, 0);
    chk("t1_rsp_v", 32'(s_cpu_rsp_v), 32'd1);
    chk("t1_rsp_d", 32'(s_cpu_rsp_d), 32'd7);

    // Crypto XOR
    set_cry(5'd0, 2'd3, 16'hF0F0, 16'h0FF0);
    step(0, 1, 0, 0);
    grant_is("t2_grant", 1'b0, 1'b1);
    chk("t2_flag", 32'(s_flag), 32'd0);
    step(0, 0, 0, 0);
    chk("t2_rsp_v", 32'(s_cry_rsp_v), 32'd1);
    chk("t2_rsp_d", 32'(s_cry_rsp_d), 32'hFF00);

    // Both valid continuously: 4 CPU grants then one forced crypto grant
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      rand_fields();
      step(1, 1, 0, 0);
      grant_is($sformatf("t3_cycle%0d", i), (i % 5) != 4, (i % 5) == 4);
    end
`ifdef ARB_STATS_EN
    chk("t6_cpu_cnt", 32'(cpu_grant_cnt), 32'd16);
    chk("t6_cry_cnt", 32'(cry_grant_cnt), 32'd4);
    chk("t6_force_cnt", 32'(force_cnt), 32'd4);
`endif

    // Lock held: 8 crypto grants after the forced one opens the burst
    step(0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      rand_fields();
      step(1, 1, 1, 0);
      grant_is($sformatf("t4_cycle%0d", i), (i < 4) || (i > 11), (i >= 4) && (i <= 11));
    end

    // Lock dropped after 3 crypto grants: idle exit slot, then CPU
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      rand_fields();
      step(1, 1, i != 7, 0);
      grant_is($sformatf("t4b_cycle%0d", i), (i < 4) || (i == 8), (i >= 4) && (i <= 6));
    end

    // Reset mid-burst the cycle after a crypto grant
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      step(1, 1, 1, 0);
    end
    grant_is("t5_pre_grant", 1'b0, 1'b1);
    step(1, 1, 1, 1);
    chk("t5_rst_rsp", 32'(s_cry_rsp_v), 32'd0);
    grant_is("t5_rst_grant", 1'b0, 1'b0);
    step(1, 1, 1, 0);
    grant_is("t5_post_grant", 1'b1, 1'b0);
    chk("t5_post_rsp", 32'(s_cry_rsp_v), 32'd0);

    // Randomized traffic with occasional resets
    step(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) == 0, ($urandom % 60) == 0);
    end
`ifdef ARB_STATS_EN
    chk("rand_cpu_cnt", 32'(cpu_grant_cnt), 32'(m_cpu));
    chk("rand_cry_cnt", 32'(cry_grant_cnt), 32'(m_cry));
    chk("rand_force_cnt", 32'(force_cnt), 32'(m_force));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
